pipe_hazard_seq: RTL
====================

Name: pipe_hazard_seq

Overview:
Pipeline hazard sequencer for the 5-stage core. It takes the hazard detection unit's stall and flush requests and the data-memory busy signal, and produces the per-stage write enables, the IF/ID flush and the ID/EX bubble. It supports multi-cycle load stalls, multi-cycle flushes and memory-wait freezes, and keeps saturating stall and flush performance counters.

Parameters:
LOAD_STALL_CYCLES, 1, number of bubble cycles inserted per accepted stall_req (legal 1..15).
FLUSH_CYCLES, 1, number of flush cycles per accepted flush_req (legal 1..15).
CNT_W, 16, width of the performance counters.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst  input  1  synchronous, active-high reset.
stall_req  input  1  load-use stall request from the hazard detection unit.
flush_req  input  1  branch flush request from the hazard detection unit.
dmem_busy  input  1  data memory not ready; the whole pipeline must freeze.
cnt_clr  input  1  synchronous clear of both counters.
pc_write  output  1  PC register write enable.
ifid_write  output  1  IF/ID register write enable.
ifid_flush  output  1  IF/ID register loads a NOP.
idex_write  output  1  ID/EX register write enable.
idex_bubble  output  1  ID/EX register loads zeroed control (bubble).
exmem_write  output  1  EX/MEM register write enable.
memwb_write  output  1  MEM/WB register write enable.
state_o  output  2  current state: 0=RUN, 1=LSTALL, 2=FLUSH, 3=MWAIT.
stall_cnt  output  CNT_W  number of cycles with pc_write=0; saturates.
flush_cnt  output  CNT_W  number of accepted flush events; saturates.

Behaviour:
- Outputs are Mealy: a combinational function of the registered state and the current-cycle requests, so a hazard takes effect in the same cycle it is detected.
- Output patterns:
  - NORMAL: all *_write=1, ifid_flush=0, idex_bubble=0.
  - STALLP: pc_write=0, ifid_write=0, idex_bubble=1, all other writes=1.
  - FLUSHP: all writes=1, ifid_flush=1, idex_bubble=1.
  - FREEZE: all writes=0, ifid_flush=0, idex_bubble=0.
- Request priority every cycle: dmem_busy > flush_req > stall_req.
- RUN state:
  - dmem_busy=1: FREEZE; ret<=RUN; go to MWAIT.
  - Else flush_req=1: FLUSHP; flush_cnt++; if FLUSH_CYCLES>1, fl_left<=FLUSH_CYCLES-1 and go to FLUSH.
  - Else stall_req=1: STALLP; if LOAD_STALL_CYCLES>1, ls_left<=LOAD_STALL_CYCLES-1 and go to LSTALL.
  - Else: NORMAL.
- LSTALL state:
  - dmem_busy=1: FREEZE; ret<=LSTALL; ls_left held; go to MWAIT.
  - Else flush_req=1: the stall is aborted and the flush is handled exactly as in RUN.
  - Else: STALLP regardless of stall_req; ls_left--; when ls_left reaches 0, go to RUN.
- FLUSH state:
  - dmem_busy=1: FREEZE; ret<=FLUSH; fl_left held; go to MWAIT.
  - Else: FLUSHP; fl_left--; when fl_left reaches 0, go to RUN.
  - stall_req is ignored (the requesting instruction is being flushed).
  - A new flush_req restarts fl_left at FLUSH_CYCLES-1 and increments flush_cnt.
- MWAIT state:
  - FREEZE while dmem_busy=1.
  - flush_req seen while in MWAIT sets pend_flush.
  - On the first cycle with dmem_busy=0: return to ret. If pend_flush or flush_req is set, that cycle is processed as a flush from RUN, pend_flush is cleared, and flush_cnt increments once only.
  - A stall_req seen during MWAIT is not latched.
- Counters:
  - stall_cnt increments on every cycle with pc_write=0 (STALLP or FREEZE).
  - flush_cnt increments once per accepted flush.
  - Both saturate at all-ones.
  - cnt_clr zeroes both counters; clear wins over a same-cycle increment.
- Reset:
  - While rst=1: outputs forced to NORMAL; state=RUN; ls_left, fl_left, pend_flush, ret and both counters =0.
  - Requests present in a reset cycle are discarded.
  - Reset mid-stall, mid-flush or mid-wait aborts the sequence immediately.
- Registered state: state (2 bits), ret (2 bits), ls_left and fl_left (4 bits each), pend_flush, and the two counters.

Test Plan:
- Reset, then idle 3 cycles: NORMAL every cycle; state_o=0; stall_cnt=0 and flush_cnt=0.
- LOAD_STALL_CYCLES=2; stall_req pulsed 1 cycle: STALLP for 2 cycles, then NORMAL; state_o sequence 0,1,0; stall_cnt=2.
- FLUSH_CYCLES=2; flush_req and stall_req together: FLUSHP for 2 cycles; no STALLP; flush_cnt=1; stall_cnt=0.
- dmem_busy held 3 cycles mid-LSTALL with ls_left=1: FREEZE ×3, one more STALLP cycle, then RUN; stall_cnt=5 in total (1+3+1).
- flush_req pulsed during MWAIT, dmem_busy drops 2 cycles later: FLUSHP on the first non-busy cycle; flush_cnt=1.
- CNT_W=4, stall_req held 20 cycles: stall_cnt saturates at 15; cnt_clr asserted together with stall_req gives stall_cnt=0 on the next cycle.

Source files
------------

// File: rtl/pipe_hazard_seq.sv
// Pipeline hazard sequencer for the 5-stage core.
// Turns stall/flush requests and data-memory busy into per-stage write
// enables, an IF/ID flush and an ID/EX bubble. Outputs are Mealy so a hazard
// acts in the cycle it is detected. Saturating stall/flush counters included.
module pipe_hazard_seq #(
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int FLUSH_CYCLES      = 1,
   parameter int CNT_W             = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall_req,
   input  logic             flush_req,
   input  logic             dmem_busy,
   input  logic             cnt_clr,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_write,
   output logic             idex_bubble,
   output logic             exmem_write,
   output logic             memwb_write,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      LSTALL = 2'd1,
      FLUSH  = 2'd2,
      MWAIT  = 2'd3
   } stateT;

   // Control bundle order: pc, ifidW, ifidFlush, idexW, idexBubble, exmemW, memwbW
   localparam logic [6:0] P_NORMAL = 7'b1101011;
   localparam logic [6:0] P_STALL  = 7'b0001111;
   localparam logic [6:0] P_FLUSH  = 7'b1111111;
   localparam logic [6:0] P_FREEZE = 7'b0000000;

   localparam logic [3:0] LS_RELOAD = 4'(LOAD_STALL_CYCLES - 1);
   localparam logic [3:0] FL_RELOAD = 4'(FLUSH_CYCLES - 1);

   stateT            r_state, w_nextState;
   stateT            r_ret, w_nextRet;
   stateT            w_ctx;
   logic [3:0]       r_lsLeft, w_nextLsLeft;
   logic [3:0]       r_flLeft, w_nextFlLeft;
   logic             r_pendFlush, w_nextPendFlush;
   logic             w_flushNow;
   logic             w_flushEvent;
   logic [6:0]       w_ctl;
   logic [CNT_W-1:0] r_stallCnt, r_flushCnt;

   // Next-state and Mealy outputs. When memory releases in MWAIT, that very
   // cycle is processed as the saved state would process it (w_ctx), so no
   // cycle is lost on the way back; a latched or live flush overrides it.
   always_comb begin
      w_ctl           = P_NORMAL;
      w_nextState     = r_state;
      w_nextRet       = r_ret;
      w_nextLsLeft    = r_lsLeft;
      w_nextFlLeft    = r_flLeft;
      w_nextPendFlush = r_pendFlush;
      w_flushEvent    = 1'b0;
      w_ctx           = (r_state == MWAIT) ? r_ret : r_state;
      w_flushNow      = flush_req | ((r_state == MWAIT) & r_pendFlush);
      if (!rst) begin
         if (dmem_busy) begin
            w_ctl       = P_FREEZE;
            w_nextState = MWAIT;
            if (r_state == MWAIT) begin
               w_nextPendFlush = r_pendFlush | flush_req;
            end else begin
               w_nextRet = r_state;
            end
         end else begin
            w_nextPendFlush = 1'b0;
            w_nextState     = RUN;
            if (w_flushNow) begin
               w_ctl        = P_FLUSH;
               w_flushEvent = 1'b1;
               w_nextLsLeft = 4'd0;
               if (FLUSH_CYCLES > 1) begin
                  w_nextState  = FLUSH;
                  w_nextFlLeft = FL_RELOAD;
               end
            end else if (w_ctx == FLUSH) begin
               w_ctl        = P_FLUSH;
               w_nextFlLeft = r_flLeft - 4'd1;
               if (r_flLeft != 4'd1) begin
                  w_nextState = FLUSH;
               end
            end else if (w_ctx == LSTALL) begin
               w_ctl        = P_STALL;
               w_nextLsLeft = r_lsLeft - 4'd1;
               if (r_lsLeft != 4'd1) begin
                  w_nextState = LSTALL;
               end
            end else if (stall_req) begin
               w_ctl = P_STALL;
               if (LOAD_STALL_CYCLES > 1) begin
                  w_nextState  = LSTALL;
                  w_nextLsLeft = LS_RELOAD;
               end
            end
         end
      end
   end

   assign {pc_write, ifid_write, ifid_flush, idex_write,
           idex_bubble, exmem_write, memwb_write} = w_ctl;

   // State register; reset aborts any stall, flush or wait in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= RUN;
         r_ret       <= RUN;
         r_lsLeft    <= 4'd0;
         r_flLeft    <= 4'd0;
         r_pendFlush <= 1'b0;
      end else begin
         r_state     <= w_nextState;
         r_ret       <= w_nextRet;
         r_lsLeft    <= w_nextLsLeft;
         r_flLeft    <= w_nextFlLeft;
         r_pendFlush <= w_nextPendFlush;
      end
   end

   // Saturating performance counters; a clear beats a same-cycle increment.
   always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
         r_stallCnt <= '0;
         r_flushCnt <= '0;
      end else begin
         if (!pc_write && (r_stallCnt != '1)) begin
            r_stallCnt <= r_stallCnt + CNT_W'(1);
         end
         if (w_flushEvent && (r_flushCnt != '1)) begin
            r_flushCnt <= r_flushCnt + CNT_W'(1);
         end
      end
   end

   assign state_o   = r_state;
   assign stall_cnt = r_stallCnt;
   assign flush_cnt = r_flushCnt;

endmodule
